// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared stage bundle types, bubble constants and skid FSM states
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

  localparam int unsigned PIPE_DATA_W = 74;
  localparam int unsigned PIPE_CNT_W  = 16;

  typedef struct packed {
    logic [2:0]  alutype;
    logic [7:0]  aluop;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [4:0]  wa;
    logic        wreg;
  } id_exe_t;

  typedef struct packed {
    logic [7:0]  aluop;
    logic [31:0] wd;
    logic [4:0]  wa;
    logic        wreg;
    logic [4:0]  exccode;
  } exe_mem_t;

  typedef struct packed {
    logic [4:0]  wa;
    logic        wreg;
    logic [31:0] wd;
  } mem_wb_t;

  localparam id_exe_t  NOP_ID_EXE  = '0;
  localparam exe_mem_t NOP_EXE_MEM = '0;
  localparam mem_wb_t  NOP_MEM_WB  = '0;

  // State encoding doubles as the entry count.
  function automatic logic [1:0] state_occupancy(input skid_state_e st);
    return 2'(st);
  endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// rtl/pipe_skid_slot.sv - one valid+payload register with load and clear (clear wins)
module pipe_skid_slot
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W  = PIPE_DATA_W,
  parameter logic [DATA_W-1:0] NOP_VAL = '0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= NOP_VAL;
    end else if (i_clear) begin
      r_valid <= 1'b0;
      r_data  <= NOP_VAL;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - inter-stage pipeline register with handshake, flush and stall counter
// PIPE_SKID_EN selects the two-entry variant whose in_ready comes straight from a flop.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W  = PIPE_DATA_W,
  parameter logic [DATA_W-1:0] NOP_VAL = '0,
  parameter int unsigned       CNT_W   = PIPE_CNT_W
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              w_in_xfer;
  logic              w_out_xfer;
  logic              w_main_valid;
  logic              w_main_load;
  logic              w_main_clear;
  logic [DATA_W-1:0] w_main_din;
  logic [DATA_W-1:0] w_main_data;
  logic [CNT_W-1:0]  r_stall_cnt;

  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = w_main_valid & out_ready;

`ifdef PIPE_SKID_EN
  skid_state_e       r_state;
  skid_state_e       w_state_nxt;
  logic              r_in_ready;
  logic              w_skid_valid;
  logic              w_skid_load;
  logic              w_skid_clear;
  logic [DATA_W-1:0] w_skid_data;

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != ST_TWO);
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_main_load  = 1'b0;
    w_main_clear = 1'b0;
    w_main_din   = in_data;
    w_skid_load  = 1'b0;
    w_skid_clear = 1'b0;
    if (flush) begin
      w_state_nxt  = ST_EMPTY;
      w_main_clear = 1'b1;
      w_skid_clear = 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_xfer) begin
            w_state_nxt = ST_ONE;
            w_main_load = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            w_main_load = 1'b1;
          end else if (w_in_xfer) begin
            w_state_nxt = ST_TWO;
            w_skid_load = 1'b1;
          end else if (w_out_xfer) begin
            w_state_nxt  = ST_EMPTY;
            w_main_clear = 1'b1;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only the promotion of the skid entry can happen.
          if (w_out_xfer) begin
            w_state_nxt  = ST_ONE;
            w_main_load  = 1'b1;
            w_main_din   = w_skid_data;
            w_skid_clear = 1'b1;
          end
        end
        default: begin
          w_state_nxt  = ST_EMPTY;
          w_main_clear = 1'b1;
          w_skid_clear = 1'b1;
        end
      endcase
    end
  end

  pipe_skid_slot #(
    .DATA_W  (DATA_W),
    .NOP_VAL (NOP_VAL)
  ) u_skid (
    .i_clk   (cpu_clk_50M),
    .i_rst_n (cpu_rst_n),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_data  (in_data),
    .o_valid (w_skid_valid),
    .o_data  (w_skid_data)
  );

  assign in_ready  = r_in_ready;
  assign occupancy = state_occupancy(r_state);
`else
  // Accept whenever the slot is empty or is being drained this same edge.
  assign in_ready = !w_main_valid | out_ready;

  always_comb begin
    w_main_load  = w_in_xfer & !flush;
    w_main_clear = flush | (w_out_xfer & !w_in_xfer);
    w_main_din   = in_data;
  end

  assign occupancy = {1'b0, w_main_valid};
`endif

  pipe_skid_slot #(
    .DATA_W  (DATA_W),
    .NOP_VAL (NOP_VAL)
  ) u_main (
    .i_clk   (cpu_clk_50M),
    .i_rst_n (cpu_rst_n),
    .i_load  (w_main_load),
    .i_clear (w_main_clear),
    .i_data  (w_main_din),
    .o_valid (w_main_valid),
    .o_data  (w_main_data)
  );

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_main_valid && !out_ready && (r_stall_cnt != CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + CNT_ONE;
    end
  end

  assign out_valid = w_main_valid;
  assign out_data  = w_main_valid ? w_main_data : NOP_VAL;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - scoreboard bench for pipe_stage_buf, valid with or without PIPE_SKID_EN
module tb_pipe_stage_buf;

  localparam int DW = 74;
  localparam int CW = 4;
`ifdef PIPE_SKID_EN
  localparam logic [1:0] EXP_OCC_FULL  = 2'd2;
  localparam logic       EXP_V_RELEASE = 1'b1;
`else
  localparam logic [1:0] EXP_OCC_FULL  = 2'd1;
  localparam logic       EXP_V_RELEASE = 1'b0;
`endif

  logic          cpu_clk_50M = 1'b0;
  logic          cpu_rst_n   = 1'b1;
  logic          flush       = 1'b0;
  logic          in_valid    = 1'b0;
  logic          out_ready   = 1'b0;
  logic [DW-1:0] in_data     = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cnt;

  logic [DW-1:0] sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  pipe_stage_buf #(
    .DATA_W (DW),
    .CNT_W  (CW)
  ) dut (
    .cpu_clk_50M (cpu_clk_50M),
    .cpu_rst_n   (cpu_rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .occupancy   (occupancy),
    .stall_cnt   (stall_cnt)
  );

  always #5 cpu_clk_50M = ~cpu_clk_50M;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  // Output monitor: pops the scoreboard on each out transfer and checks bubble/hold/ready rules.
  logic [DW-1:0] m_prev_data = '0;
  logic [DW-1:0] m_exp;
  bit            m_prev_stall = 1'b0;
  always @(negedge cpu_clk_50M) begin
    if (!cpu_rst_n) begin
      m_prev_stall = 1'b0;
    end else begin
      if (m_prev_stall) begin
        chk("hold_valid", DW'(out_valid), DW'(1));
        chk("hold_data", out_data, m_prev_data);
      end
      if (!out_valid) chk("bubble_nop", out_data, '0);
`ifdef PIPE_SKID_EN
      chk("ready_reg", DW'(in_ready), DW'(occupancy != 2'd2));
`else
      chk("ready_comb", DW'(in_ready), DW'(!out_valid | out_ready));
`endif
      if (out_valid && out_ready && !flush) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_underflow: got %0h expected no output", out_data);
        end else begin
          m_exp = sb.pop_front();
          chk("sb_data", out_data, m_exp);
        end
      end
      m_prev_stall = out_valid && !out_ready && !flush;
      m_prev_data  = out_data;
    end
  end

  // One cycle of stimulus: drive at posedge+1, record acceptance at negedge, return at posedge+1.
  task automatic step_in(input bit v, input logic [DW-1:0] d, input bit rdy, input bit fl, output bit acc);
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    flush     = fl;
    @(negedge cpu_clk_50M);
    acc = v && in_ready;
    if (fl) sb.delete();
    else if (acc) sb.push_back(d);
    @(posedge cpu_clk_50M);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    in_data   = '0;
    cpu_rst_n = 1'b0;
    sb.delete();
    @(negedge cpu_clk_50M);
    #1 cpu_rst_n = 1'b1;
    @(posedge cpu_clk_50M);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    bit pend;
    logic [DW-1:0] seq;

    #1 cpu_rst_n = 1'b0;
    #2;
    chk("rst_valid", DW'(out_valid), '0);
    chk("rst_data", out_data, '0);
    chk("rst_occ", DW'(occupancy), '0);
    chk("rst_stall", DW'(stall_cnt), '0);
    @(negedge cpu_clk_50M);
    #1 cpu_rst_n = 1'b1;
    @(posedge cpu_clk_50M);
    #1;
    chk("rel_ready", DW'(in_ready), DW'(1));

    // Reset in the middle of a held bundle
    step_in(1'b1, DW'('hA5), 1'b0, 1'b0, acc);
    chk("a5_valid", DW'(out_valid), DW'(1));
    chk("a5_data", out_data, DW'('hA5));
    in_valid = 1'b0;
    #3 cpu_rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midrst_valid", DW'(out_valid), '0);
    chk("midrst_data", out_data, '0);
    chk("midrst_stall", DW'(stall_cnt), '0);
    chk("midrst_occ", DW'(occupancy), '0);
    @(negedge cpu_clk_50M);
    #1 cpu_rst_n = 1'b1;
    @(posedge cpu_clk_50M);
    #1;
    chk("midrst_ready", DW'(in_ready), DW'(1));
    chk("midrst_empty", DW'(out_valid), '0);

    // Streaming 0..9
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step_in(1'b1, DW'(i), 1'b1, 1'b0, acc);
      chk("stream_acc", DW'(acc), DW'(1));
      chk("stream_valid", DW'(out_valid), DW'(1));
      chk("stream_data", out_data, DW'(i));
      chk("stream_ready", DW'(in_ready), DW'(1));
    end
    step_in(1'b0, '0, 1'b1, 1'b0, acc);
    chk("stream_drained", DW'(out_valid), '0);

    // Downstream stall for 5 cycles
    do_reset();
    step_in(1'b1, DW'('h11), 1'b1, 1'b0, acc);
    for (int k = 0; k < 5; k++) begin
      step_in(1'b1, DW'('h12), 1'b0, 1'b0, acc);
      chk("stall_valid", DW'(out_valid), DW'(1));
      chk("stall_data", out_data, DW'('h11));
    end
    chk("stall_cnt5", DW'(stall_cnt), DW'(5));
    chk("stall_occ", DW'(occupancy), DW'(EXP_OCC_FULL));
    chk("stall_ready", DW'(in_ready), '0);
    step_in(1'b0, '0, 1'b1, 1'b0, acc);
    chk("release_valid", DW'(out_valid), DW'(EXP_V_RELEASE));
    step_in(1'b0, '0, 1'b1, 1'b0, acc);
    chk("release_drained", DW'(out_valid), '0);
    chk("release_cnt", DW'(stall_cnt), DW'(5));

    // Flush with a concurrent input
    do_reset();
    step_in(1'b1, DW'('h31), 1'b0, 1'b0, acc);
    step_in(1'b1, DW'('h32), 1'b0, 1'b0, acc);
    chk("preflush_occ", DW'(occupancy), DW'(EXP_OCC_FULL));
    chk("preflush_cnt", DW'(stall_cnt), DW'(1));
    step_in(1'b1, DW'('h33), 1'b0, 1'b1, acc);
    chk("flush_valid", DW'(out_valid), '0);
    chk("flush_occ", DW'(occupancy), '0);
    chk("flush_data", out_data, '0);
    chk("flush_cnt", DW'(stall_cnt), DW'(2));
    for (int k = 0; k < 3; k++) begin
      step_in(1'b0, '0, 1'b1, 1'b0, acc);
      chk("postflush_valid", DW'(out_valid), '0);
    end

    // Stall counter saturation at 2^CW-1
    do_reset();
    step_in(1'b1, DW'('h55), 1'b0, 1'b0, acc);
    for (int k = 1; k <= 20; k++) begin
      step_in(1'b0, '0, 1'b0, 1'b0, acc);
      if (k == 14) chk("sat_cnt14", DW'(stall_cnt), DW'(14));
    end
    chk("sat_cnt", DW'(stall_cnt), DW'(15));
    chk("sat_data", out_data, DW'('h55));
    step_in(1'b0, '0, 1'b1, 1'b0, acc);
    chk("sat_hold", DW'(stall_cnt), DW'(15));

    // Random valid/ready with occasional flush
    do_reset();
    seq  = DW'('h100);
    pend = 1'b0;
    for (int c = 0; c < 400; c++) begin
      bit v, rdy, fl;
      fl  = ($urandom_range(0, 39) == 0);
      v   = pend || ($urandom_range(0, 2) != 0);
      rdy = fl ? 1'b0 : ($urandom_range(0, 9) < 7);
      step_in(v, seq, rdy, fl, acc);
      pend = v && !acc;
      if (acc) seq = seq + DW'(1);
    end
    for (int k = 0; k < 6; k++) step_in(1'b0, '0, 1'b1, 1'b0, acc);
    chk("sb_drained", DW'(sb.size()), '0);
    chk("rand_progress", DW'(seq > DW'('h140)), DW'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
